sc_dmem_arbiter: RTL
====================

# sc_dmem_arbiter

Two-master arbiter placed in front of the single-port data RAM of the single-cycle computer. It shares the RAM between the CPU load/store port (master A) and a secondary bus master (master B, e.g. program loader or display scanner). Requests are granted in the same cycle. A fixed-priority policy favours A, and a starvation counter guarantees B a grant within a bounded number of cycles. Read data returns one cycle later, tagged to the master that issued the read.

## Interface
Parameters:
- AW, 5, RAM word-address width; RAM address = addr[AW+1:2]
- DW, 32, data width
- MAX_WAIT, 4, maximum consecutive denied cycles for B before a forced grant (legal range 1..15)

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  master A request
- a_we  in  1  master A write (1) / read (0)
- a_addr  in  32  master A byte address
- a_wdata  in  DW  master A write data
- a_gnt  out  1  master A granted this cycle (combinational)
- a_rvalid  out  1  master A read data valid
- a_rdata  out  DW  master A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for master B
- ram_addr  out  AW  word address to RAM
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered inside the RAM (1-cycle latency)
- starve_flag  out  1  high during a forced-B cycle (debug / LED)

## Operation
- The RAM issues one access per cycle. The granted master drives ram_addr, ram_we and ram_wdata through a combinational mux.
- FSM, 2 states:
  - PRIO_A (reset state): grant A if a_req, else grant B if b_req, else no grant.
  - FORCE_B: grant B regardless of a_req; a_gnt = 0; starve_flag = 1.
- wait_cnt is 4 bits, reset 0.
  - Increments each cycle in which b_req = 1 and b_gnt = 0.
  - Clears on any b_gnt or on b_req = 0.
- Transition PRIO_A -> FORCE_B occurs at the edge where wait_cnt == MAX_WAIT-1 and B is denied. B is therefore denied at most MAX_WAIT consecutive cycles.
- FORCE_B -> PRIO_A is unconditional after one cycle.
- Handshake rule: a master holds req, we, addr and wdata stable until it sees gnt. It may drop req or issue a new request in the cycle after gnt. If b_req drops while in FORCE_B (protocol violation), no grant is issued and the FSM still returns to PRIO_A.
- When no master is granted: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Read return:
  - owner register (2 bits: valid + id) captures a granted read.
  - Next cycle, the owner's rvalid = 1 and its rdata = ram_rdata.
  - The non-owner's rdata = 0.
- Writes produce no rvalid.
- Back-to-back reads from alternating masters are supported at full rate. Each rvalid follows its own grant by exactly one cycle.

## Timing
- Grant latency: 0 cycles (combinational from req and state).
- Read latency: rvalid exactly 1 cycle after the gnt cycle.
- Write takes effect at the clock edge ending the gnt cycle.
- Reset values:
  - a_gnt = b_gnt = 0 while reset = 1 (gated), with ram_we = 0.
  - state = PRIO_A, wait_cnt = 0, owner invalid.
  - a_rvalid = b_rvalid = 0 and starve_flag = 0 in the cycle after reset.
- Reset asserted mid-operation: any pending read return is discarded (no rvalid after reset) and the forced-B cycle is cancelled.
- Simultaneous requests in PRIO_A: A wins. In FORCE_B: B wins.
- MAX_WAIT = 1: FORCE_B follows every single denied B cycle, giving strict alternation under continuous contention.

## Structure
- Shared package sc_arb_pkg holds:
  - the state encoding (PRIO_A = 1'b0, FORCE_B = 1'b1)
  - the owner id constants (OWN_A = 0, OWN_B = 1)
  - the default MAX_WAIT
- One natural sub-module: sc_arb_starve_cnt (wait_cnt plus its terminal-count compare), instantiated once. The grant mux and owner register stay in the top module.

## Test plan
- Reset: hold reset 3 cycles with a_req = b_req = 1 -> no gnt, ram_we = 0. Release -> a_gnt in the first cycle, state = PRIO_A.
- Solo reads:
  - A reads addr 0x0000_0008 with RAM word 2 = 0x1234_5678 -> a_gnt same cycle, ram_addr = 2, a_rvalid and a_rdata = 0x1234_5678 next cycle, b_rvalid stays 0.
  - Repeat for B only.
- Write: B writes 0xDEAD_BEEF to 0x0000_0010 with A idle -> ram_we = 1, ram_addr = 4 for one cycle. A subsequent A read of 0x10 returns 0xDEAD_BEEF.
- Starvation (MAX_WAIT = 4): A and B request continuously -> a_gnt for 4 cycles, then b_gnt with starve_flag = 1 in cycle 5, then A again. The pattern repeats every 5 cycles.
- Interleaved reads: A read word 1 (0x11), then B read word 3 (0x33) in consecutive cycles -> a_rvalid with 0x11 in cycle 2 and b_rvalid with 0x33 in cycle 3. Each rdata appears only on its owner.
- Mid-read reset: A read granted, reset asserted the next cycle -> a_rvalid = 0, wait_cnt = 0, state = PRIO_A.

Source files
------------

// File: rtl/sc_arb_pkg.sv
// Shared definitions for the single-cycle computer data-RAM arbiter:
// FSM state encoding, read-owner ids and the default starvation bound.
package sc_arb_pkg;

    typedef enum logic {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } arb_state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int unsigned DEF_MAX_WAIT = 4;

    typedef struct packed {
        logic valid;
        logic id;
    } owner_t;

    function automatic logic is_owner(input owner_t own, input logic id);
        return own.valid && (own.id == id);
    endfunction

endpackage

// File: rtl/sc_dmem_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the data RAM.
interface sc_dmem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_req;
    logic          a_we;
    logic [31:0]   a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [31:0]   b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          starve_flag;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output starve_flag
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  starve_flag
    );

endinterface

// File: rtl/sc_arb_starve_cnt.sv
// Counts consecutive cycles in which master B is denied and flags when the
// next denial would exceed the allowed bound.
module sc_arb_starve_cnt
    import sc_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    input  logic b_req,
    input  logic b_gnt,
    output logic at_term
);

    localparam logic [3:0] TERM_CNT = 4'(MAX_WAIT - 1);

    logic [3:0] wait_cnt_r;

    // Denial run-length counter; any grant or idle cycle restarts the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (b_req && !b_gnt) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Depends only on the registered count so the grant logic sees no loop.
    assign at_term = (wait_cnt_r == TERM_CNT);

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Fixed-priority (A first) arbiter for the single-port data RAM with a
// starvation guard for B and one-cycle tagged read-data return.
module sc_dmem_arbiter
    import sc_arb_pkg::*;
#(
    parameter int          AW       = 5,
    parameter int          DW       = 32,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    sc_dmem_arbiter_if.slave  bus
);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    owner_t        owner_r;
    logic          a_gnt_s;
    logic          b_gnt_s;
    logic          at_term_s;
    logic          a_rvalid_s;
    logic          b_rvalid_s;
    logic [AW-1:0] ram_addr_s;
    logic          ram_we_s;
    logic [DW-1:0] ram_wdata_s;
    logic          unused_addr_bits_s;

    assign unused_addr_bits_s = ^{bus.a_addr[31:AW+2], bus.a_addr[1:0],
                                  bus.b_addr[31:AW+2], bus.b_addr[1:0]};

    sc_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
        .clock   (clock),
        .reset   (reset),
        .b_req   (bus.b_req),
        .b_gnt   (b_gnt_s),
        .at_term (at_term_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= PRIO_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grants and next state; grants are forced low while reset is high.
    always_comb begin
        a_gnt_s     = 1'b0;
        b_gnt_s     = 1'b0;
        state_nxt_s = PRIO_A;
        if (reset) begin
            state_nxt_s = PRIO_A;
        end else begin
            case (state_r)
                PRIO_A: begin
                    if (bus.a_req) begin
                        a_gnt_s = 1'b1;
                    end else if (bus.b_req) begin
                        b_gnt_s = 1'b1;
                    end else begin
                        a_gnt_s = 1'b0;
                    end
                    if (bus.b_req && !b_gnt_s && at_term_s) begin
                        state_nxt_s = FORCE_B;
                    end else begin
                        state_nxt_s = PRIO_A;
                    end
                end
                FORCE_B: begin
                    // A dropped b_req here is a protocol error: no grant, still return.
                    b_gnt_s     = bus.b_req;
                    state_nxt_s = PRIO_A;
                end
                default: begin
                    state_nxt_s = PRIO_A;
                end
            endcase
        end
    end

    // RAM port mux; an idle cycle drives all-zero so the RAM sees no stray write.
    always_comb begin
        ram_addr_s  = '0;
        ram_we_s    = 1'b0;
        ram_wdata_s = '0;
        if (a_gnt_s) begin
            ram_addr_s  = bus.a_addr[AW+1:2];
            ram_we_s    = bus.a_we;
            ram_wdata_s = bus.a_wdata;
        end else if (b_gnt_s) begin
            ram_addr_s  = bus.b_addr[AW+1:2];
            ram_we_s    = bus.b_we;
            ram_wdata_s = bus.b_wdata;
        end else begin
            ram_addr_s  = '0;
        end
    end

    // Read owner tag: which master the RAM's next registered data belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r <= '0;
        end else begin
            owner_r.valid <= (a_gnt_s && !bus.a_we) || (b_gnt_s && !bus.b_we);
            owner_r.id    <= b_gnt_s ? OWN_B : OWN_A;
        end
    end

    assign a_rvalid_s = !reset && is_owner(owner_r, OWN_A);
    assign b_rvalid_s = !reset && is_owner(owner_r, OWN_B);

    assign bus.a_gnt       = a_gnt_s;
    assign bus.b_gnt       = b_gnt_s;
    assign bus.a_rvalid    = a_rvalid_s;
    assign bus.b_rvalid    = b_rvalid_s;
    assign bus.a_rdata     = a_rvalid_s ? bus.ram_rdata : '0;
    assign bus.b_rdata     = b_rvalid_s ? bus.ram_rdata : '0;
    assign bus.ram_addr    = ram_addr_s;
    assign bus.ram_we      = ram_we_s;
    assign bus.ram_wdata   = ram_wdata_s;
    assign bus.starve_flag = !reset && (state_r == FORCE_B);

endmodule
